// File: rtl/imem_loader_if.sv
// Bus bundle between the instruction-memory loader and its surroundings.
//   slave  : loader side (takes start and the byte stream, drives the memory write
//            port and status)
//   master : the side that supplies the byte stream and observes status
// Signals:
//   start      load request pulse
//   byte_valid / byte_data / byte_ready   byte stream handshake
//   we / a / din                           instruction-memory write port
//   busy / cpu_hold / done / cks_err       load status
interface imem_loader_if #(
    parameter int AW = 6
);
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          we;
    logic [AW-1:0] a;
    logic [31:0]   din;
    logic          busy;
    logic          cpu_hold;
    logic          done;
    logic          cks_err;

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, we, a, din, busy, cpu_hold, done, cks_err
    );

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, we, a, din, busy, cpu_hold, done, cks_err
    );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs incoming bytes little-endian into 32-bit
// words, writes NWORDS words to consecutive instruction-memory locations, then
// checks a trailing checksum byte (sum of all bytes incl. checksum == 0 mod 256).
// The CPU is held in reset while a load is in progress.
// Ports:
//   clk   clock, all logic on posedge
//   rst   synchronous active-high reset
//   bus   imem_loader_if.slave: start, byte stream handshake, memory write
//         port (we/a/din) and status (busy/cpu_hold/done/cks_err)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no load since reset; waiting for start
// COLLECT | accepting the 4 bytes of the current word
// WRITE   | one-cycle memory write of the assembled word
// CHECK   | accepting the trailing checksum byte
// DONE    | load finished, result in cks_err; start reloads
module imem_loader #(
    parameter int AW     = 6,
    parameter int NWORDS = 64
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

    state_t        state, state_nx;
    logic [AW-1:0] addr;
    logic [1:0]    bcnt;
    logic [23:0]   word_lo;
    logic [7:0]    sum;
    logic [7:0]    cks_sum;
    logic          cks_err_q;
    logic [AW-1:0] a_q;
    logic [31:0]   din_q;
    logic          byte_ready_c;
    logic          load_start;
    logic          xfer;

    always_comb begin
        state_nx     = state;
        byte_ready_c = 1'b0;
        load_start   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load_start = 1'b1;
                    state_nx   = COLLECT;
                end
            end
            COLLECT: begin
                byte_ready_c = 1'b1;
                if (bus.byte_valid && bcnt == 2'd3)
                    state_nx = WRITE;
            end
            WRITE: begin
                state_nx = (addr == LAST_ADDR) ? CHECK : COLLECT;
            end
            CHECK: begin
                byte_ready_c = 1'b1;
                if (bus.byte_valid)
                    state_nx = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    load_start = 1'b1;
                    state_nx   = COLLECT;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign xfer    = byte_ready_c && bus.byte_valid;
    assign cks_sum = sum + bus.byte_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            bcnt      <= '0;
            word_lo   <= '0;
            sum       <= '0;
            cks_err_q <= 1'b0;
            a_q       <= '0;
            din_q     <= '0;
        end else begin
            state <= state_nx;
            if (load_start) begin
                addr      <= '0;
                bcnt      <= '0;
                sum       <= '0;
                cks_err_q <= 1'b0;
            end
            if (state == COLLECT && xfer) begin
                sum  <= cks_sum;
                bcnt <= bcnt + 2'd1;   // wraps 3 -> 0 on the last byte of a word
                case (bcnt)
                    2'd0: word_lo[7:0]   <= bus.byte_data;
                    2'd1: word_lo[15:8]  <= bus.byte_data;
                    2'd2: word_lo[23:16] <= bus.byte_data;
                    default: begin
                        // Register the write port here so a/din are already
                        // valid during WRITE and simply hold afterwards.
                        a_q   <= addr;
                        din_q <= {bus.byte_data, word_lo};
                    end
                endcase
            end
            if (state == WRITE && addr != LAST_ADDR)
                addr <= addr + 1'b1;
            if (state == CHECK && xfer)
                cks_err_q <= (cks_sum != 8'd0);
        end
    end

    assign bus.byte_ready = byte_ready_c;
    assign bus.we         = (state == WRITE);
    assign bus.a          = a_q;
    assign bus.din        = din_q;
    assign bus.busy       = (state == COLLECT) || (state == WRITE) || (state == CHECK);
    assign bus.cpu_hold   = bus.busy;
    assign bus.done       = (state == DONE);
    assign bus.cks_err    = cks_err_q;
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    localparam int AW = 6;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if #(.AW(AW)) bus ();

    imem_loader #(.AW(AW), .NWORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // write log and busy-cycle counter, sampled mid-cycle
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];
    int            busy_cnt = 0;

    always @(negedge clk) begin
        if (bus.we) begin
            wa.push_back(bus.a);
            wd.push_back(bus.din);
        end
        if (bus.busy) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [AW-1:0] ea,
                          input logic [31:0] ed);
        if (idx < wa.size()) begin
            chk({tag, "_a"}, 32'(wa[idx]), 32'(ea));
            chk({tag, "_d"}, wd[idx], ed);
        end else begin
            chk({tag, "_count"}, wa.size(), idx + 1);
        end
    endtask

    // all stimulus tasks are entered and left on a negedge
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.byte_ready) chk("byte_ready_timeout", bus.byte_ready, 1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) chk({tag, "_done_timeout"}, bus.done, 1);
    endtask

    int b0;
    int c0;

    initial begin
        // 1) reset, with byte_valid high
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_byte_ready", bus.byte_ready, 0);
        chk("rst_we",         bus.we, 0);
        chk("rst_busy",       bus.busy, 0);
        chk("rst_cpu_hold",   bus.cpu_hold, 0);
        chk("rst_done",       bus.done, 0);
        chk("rst_cks_err",    bus.cks_err, 0);
        chk("rst_a",          32'(bus.a), 0);
        chk("rst_din",        bus.din, 0);
        rst            = 1'b0;
        bus.byte_valid = 1'b0;
        @(negedge clk);

        // 2) two words, good checksum: 13+93+10 = B6, B6+4A = 100
        b0 = wa.size();
        c0 = busy_cnt;
        pulse_start();
        chk("t2_busy", bus.busy, 1);
        chk("t2_hold", bus.cpu_hold, 1);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        send_byte(8'h4A);
        wait_done("t2");
        chk("t2_nwr", wa.size() - b0, 2);
        chk_wr("t2_w0", b0,     0, 32'h0000_0013);
        chk_wr("t2_w1", b0 + 1, 1, 32'h0010_0093);
        chk("t2_done",    bus.done, 1);
        chk("t2_cks_err", bus.cks_err, 0);
        chk("t2_cycles",  busy_cnt - c0, 11);
        chk("t2_hold_a",  32'(bus.a), 1);
        chk("t2_hold_d",  bus.din, 32'h0010_0093);
        chk("t2_ready",   bus.byte_ready, 0);

        // 3) same stream, checksum 3B: B6+3B = F1, not zero
        b0 = wa.size();
        pulse_start();
        chk("t3_done_clr", bus.done, 0);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        send_byte(8'h3B);
        wait_done("t3");
        chk("t3_nwr", wa.size() - b0, 2);
        chk_wr("t3_w0", b0,     0, 32'h0000_0013);
        chk_wr("t3_w1", b0 + 1, 1, 32'h0010_0093);
        chk("t3_cks_err", bus.cks_err, 1);

        // 4) 3-cycle stall between bytes 2 and 3; sums 0E+AA = B8, checksum 48
        b0 = wa.size();
        pulse_start();
        chk("t4_cks_clr", bus.cks_err, 0);
        send_byte(8'hDD);
        send_byte(8'hCC);
        repeat (3) @(negedge clk);
        send_byte(8'hBB);
        chk("t4_no_early_we", wa.size() - b0, 0);
        send_byte(8'hAA);
        chk("t4_we",  bus.we, 1);
        chk("t4_a",   32'(bus.a), 0);
        chk("t4_din", bus.din, 32'hAABB_CCDD);
        send_word(32'h4433_2211);
        send_byte(8'h48);
        wait_done("t4");
        chk("t4_nwr", wa.size() - b0, 2);
        chk_wr("t4_w1", b0 + 1, 1, 32'h4433_2211);
        chk("t4_cks_err", bus.cks_err, 0);

        // 5) reset after 6 bytes, then a fresh load
        pulse_start();
        send_word(32'hDEAD_BEEF);
        send_byte(8'h01);
        send_byte(8'h02);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy",     bus.busy, 0);
        chk("t5_cpu_hold", bus.cpu_hold, 0);
        chk("t5_done",     bus.done, 0);
        rst = 1'b0;
        @(negedge clk);
        b0 = wa.size();
        pulse_start();
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        send_byte(8'hFD);
        wait_done("t5");
        chk("t5_nwr", wa.size() - b0, 2);
        chk_wr("t5_w0", b0,     0, 32'h0000_0001);
        chk_wr("t5_w1", b0 + 1, 1, 32'h0000_0002);
        chk("t5_cks_err", bus.cks_err, 0);

        // 6) start mid-load is ignored; start in DONE restarts. 14+24 = 38, checksum C8
        b0 = wa.size();
        pulse_start();
        send_word(32'h1234_5678);
        send_byte(8'hF0);
        pulse_start();
        chk("t6_still_busy", bus.busy, 1);
        send_byte(8'hDE);
        send_byte(8'hBC);
        send_byte(8'h9A);
        send_byte(8'hC8);
        wait_done("t6");
        chk("t6_nwr", wa.size() - b0, 2);
        chk_wr("t6_w0", b0,     0, 32'h1234_5678);
        chk_wr("t6_w1", b0 + 1, 1, 32'h9ABC_DEF0);
        chk("t6_cks_err", bus.cks_err, 0);
        b0 = wa.size();
        pulse_start();
        chk("t6_restart_done", bus.done, 0);
        chk("t6_restart_busy", bus.busy, 1);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        send_byte(8'h4A);
        wait_done("t6r");
        chk_wr("t6r_w0", b0, 0, 32'h0000_0013);
        chk("t6r_nwr", wa.size() - b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
